// File: rtl/timer_sequencer.sv
// Loadable down-counting timer with one-shot / auto-reload modes,
// pause (HOLD) and abort, plus a one-cycle registered expiry pulse.
module timer_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             periodic,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_d;

  // Every output comes straight from a register (busy decodes the state register).
  assign state = state_q;
  assign busy  = (state_q != IDLE);

  // State, counter, reload value and expiry pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count    <= '0;
      reload_q <= '0;
      expired  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      reload_q <= reload_d;
      expired  <= expired_d;
    end
  end

  // Next-state logic; the if-chain order encodes abort > start > pause > decrement.
  always_comb begin
    state_d   = state_q;
    count_d   = count;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (abort) begin
      // Abort blocks any start on the same edge; in IDLE there is nothing to cancel.
      if (state_q != IDLE) begin
        state_d = IDLE;
        count_d = '0;
      end
    end else if (start) begin
      reload_d = load_val;
      if (load_val != '0) begin
        state_d = RUN;
        count_d = load_val;
      end else begin
        // A zero-length timer expires immediately without leaving IDLE.
        state_d   = IDLE;
        count_d   = '0;
        expired_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (en) begin
            if (count > ONE) begin
              count_d = count - ONE;
            end else if (count == ONE) begin
              expired_d = 1'b1;
              if (periodic) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end
          end
        end
        HOLD: begin
          // Leaving HOLD costs one edge; decrementing resumes on the next one.
          if (!pause) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: directed scenarios followed by random stimulus,
// all outputs compared every cycle against a behavioural reference model.
module tb_timer_sequencer;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst, en, start, periodic, pause, abort;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy, expired;
  logic [1:0]       state;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = held.
  int m_mode, m_count, m_reload, m_exp;

  timer_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .load_val(load_val),
    .periodic(periodic), .pause(pause), .abort(abort),
    .count(count), .busy(busy), .expired(expired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    vectors++;
    if (obs != exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Applies the timer rules to the inputs seen at this edge.
  task automatic model_edge();
    int nexp;
    nexp = 0;
    if (rst) begin
      m_mode = 0; m_count = 0; m_reload = 0;
    end else if (abort) begin
      if (m_mode != 0) begin
        m_mode = 0; m_count = 0;
      end
    end else if (start) begin
      m_reload = int'(load_val);
      if (load_val != 0) begin
        m_mode = 1; m_count = int'(load_val);
      end else begin
        m_mode = 0; m_count = 0; nexp = 1;
      end
    end else if (m_mode == 1 && pause) begin
      m_mode = 2;
    end else if (m_mode == 2) begin
      if (!pause) m_mode = 1;
    end else if (m_mode == 1 && en) begin
      if (m_count > 1) m_count = m_count - 1;
      else begin
        nexp = 1;
        if (periodic) m_count = m_reload;
        else begin
          m_count = 0; m_mode = 0;
        end
      end
    end
    m_exp = nexp;
  endtask

  task automatic compare_all();
    check("count", int'(count), m_count);
    check("state", int'(state), m_mode);
    check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    check("expired", int'(expired), m_exp);
  endtask

  // One clock: model updates at the edge, outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet();
    rst = 0; en = 0; start = 0; periodic = 0; pause = 0; abort = 0; load_val = '0;
  endtask

  initial begin
    m_mode = 0; m_count = 0; m_reload = 0; m_exp = 0;
    quiet();

    // Reset with random other inputs.
    for (int i = 0; i < 2; i++) begin
      rst = 1; en = 1'($urandom); start = 1'($urandom); pause = 1'($urandom);
      abort = 1'($urandom); periodic = 1'($urandom); load_val = WIDTH'($urandom);
      step();
    end
    check("rst_count", int'(count), 0);
    check("rst_state", int'(state), 0);

    // One-shot from 5.
    quiet(); load_val = 5; start = 1; en = 1;
    step();
    check("os_load", int'(count), 5);
    start = 0;
    for (int v = 4; v >= 0; v--) begin
      step();
      check("os_count", int'(count), v);
      check("os_exp", int'(expired), (v == 0) ? 1 : 0);
    end
    check("os_idle", int'(state), 0);
    step();
    check("os_exp_clear", int'(expired), 0);

    // Periodic reload of 3.
    quiet(); load_val = 3; periodic = 1; en = 1; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("per_count", int'(count), 3 - ((i + 1) % 3));
      check("per_busy", int'(busy), 1);
    end

    // Pause at 4 for three cycles.
    quiet(); load_val = 6; en = 1; start = 1;
    step();
    start = 0;
    step(); step();
    check("pz_at4", int'(count), 4);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pz_hold", int'(count), 4);
      check("pz_state", int'(state), 2);
    end
    pause = 0;
    step();
    check("pz_resume0", int'(count), 4);
    step();
    check("pz_resume1", int'(count), 3);

    // Abort beats start; then zero-length start from IDLE.
    quiet(); load_val = 5; en = 1; start = 1;
    step();
    start = 0;
    step(); step(); step();
    check("ab_at2", int'(count), 2);
    abort = 1; start = 1; load_val = 7;
    step();
    check("ab_count", int'(count), 0);
    check("ab_state", int'(state), 0);
    check("ab_exp", int'(expired), 0);
    quiet(); load_val = 0; start = 1;
    step();
    check("z_exp", int'(expired), 1);
    check("z_state", int'(state), 0);
    start = 0;
    step();
    check("z_exp_clear", int'(expired), 0);

    // Reset mid-run, then en=0 hold in RUN.
    quiet(); load_val = 5; en = 1; start = 1;
    step();
    start = 0;
    step(); step();
    check("rr_at3", int'(count), 3);
    rst = 1;
    step();
    check("rr_count", int'(count), 0);
    check("rr_busy", int'(busy), 0);
    quiet(); load_val = 5; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("en0_hold", int'(count), 5);
    end

    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      abort    = ($urandom_range(0, 19) == 0);
      start    = ($urandom_range(0, 7) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      en       = ($urandom_range(0, 3) != 0);
      periodic = 1'($urandom);
      load_val = WIDTH'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 Parameter: WIDTH, default 3, bit width of the count and load value.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 en  input  1  count enable; decrement permitted only when 1.
REQ-005 start  input  1  load/launch request, sampled each rising edge.
REQ-006 load_val  input  WIDTH  start value captured on an accepted start.
REQ-007 periodic  input  1  1 = auto-reload on expiry; 0 = one-shot.
REQ-008 pause  input  1  level hold request.
REQ-009 abort  input  1  cancel request.
REQ-010 count  output  WIDTH  current counter value, registered.
REQ-011 busy  output  1  1 while state is RUN or HOLD.
REQ-012 expired  output  1  one-cycle registered expiry pulse.
REQ-013 state  output  2  IDLE=00, RUN=01, HOLD=10; 11 never driven.

Function
REQ-014 Input priority each edge SHALL be: rst > abort > start > pause > decrement.
REQ-015 reload register SHALL capture load_val on every accepted start; it is otherwise unchanged.
REQ-016 IDLE, start=1, load_val!=0: count<=load_val, state<=RUN on the same edge; count reads load_val in the next cycle.
REQ-017 IDLE, start=1, load_val==0: state stays IDLE, count stays 0, expired=1 for the following cycle.
REQ-018 First decrement SHALL occur no earlier than the edge after start is accepted (load cycle never decrements).
REQ-019 RUN, en=1, count>1: count<=count-1.
REQ-020 RUN, en=0: count and state hold; no expiry.
REQ-021 RUN, en=1, count==1, periodic=0: count<=0, state<=IDLE, expired=1 for the following cycle.
REQ-022 RUN, en=1, count==1, periodic=1: count<=reload, state stays RUN, expired=1 for the following cycle; count never reads 0.
REQ-023 periodic SHALL be sampled only at the terminal decrement edge; changes mid-run take effect at next expiry.
REQ-024 RUN, pause=1: state<=HOLD, count frozen on that edge (no decrement even if en=1).
REQ-025 HOLD, pause=0: state<=RUN; decrement resumes on the following edge if en=1.
REQ-026 HOLD SHALL ignore en; count constant throughout.
REQ-027 abort in RUN or HOLD: count<=0, state<=IDLE, expired stays 0; abort in IDLE has no effect.
REQ-028 start in RUN or HOLD (no abort): restart per REQ-016/017; pause on the same edge is ignored, state<=RUN.
REQ-029 expired SHALL be 0 in every cycle not named in REQ-017/021/022; never high two consecutive cycles unless reload value is 1 and en stays 1.
REQ-030 Arithmetic is unsigned WIDTH-bit; count SHALL never wrap below 0.

Reset
REQ-031 On rst=1 at an edge: count=0, state=IDLE, busy=0, expired=0, reload register=0, regardless of state or other inputs.
REQ-032 All outputs SHALL be valid from the first edge with rst=1; no reset-to-output combinational path.

Verification
REQ-033 rst=1 two cycles, other inputs random -> count=000, state=00, busy=0, expired=0.
REQ-034 load_val=5, start one cycle, en=1, periodic=0 -> count 5,4,3,2,1,0; expired=1 only in the cycle count=0; state=00, busy=0 there.
REQ-035 load_val=3, periodic=1, en=1 for 10 cycles -> count 3,2,1,3,2,1,3...; expired=1 in each cycle following reload to 3; busy stays 1.
REQ-036 load_val=6 run, pause=1 when count=4 for 3 cycles -> count holds 4, state=10; pause=0 -> next values 4 then 3.
REQ-037 Running at count=2, abort=1 and start=1 same edge -> count=0, state=00, expired=0; load_val=0 start from IDLE -> expired=1 one cycle, state=00.
REQ-038 Running at count=3, rst=1 one edge -> count=0, state=00, busy=0; en=0 in RUN for 4 cycles -> count unchanged.
